// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the ALU operand/result
// wires, the response channel and the grant counters of alu_arbiter.
// slave  = the arbiter side, master = the environment (requesters, ALU, consumer).
interface alu_arbiter_if #(
  parameter int CMD_W  = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              r0_valid;
  logic              r0_ready;
  logic [CMD_W-1:0]  r0_cmd;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;

  logic              r1_valid;
  logic              r1_ready;
  logic [CMD_W-1:0]  r1_cmd;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;

  logic [CMD_W-1:0]  alu_cmd;
  logic [DATA_W-1:0] alu_inA;
  logic [DATA_W-1:0] alu_inB;
  logic [DATA_W-1:0] alu_rslt;
  logic              alu_branch;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rslt;
  logic              rsp_branch;

  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  r0_valid, r0_cmd, r0_a, r0_b,
    output r0_ready,
    input  r1_valid, r1_cmd, r1_a, r1_b,
    output r1_ready,
    output alu_cmd, alu_inA, alu_inB,
    input  alu_rslt, alu_branch,
    output rsp_valid, rsp_id, rsp_rslt, rsp_branch,
    input  rsp_ready,
    output cnt0, cnt1
  );

  modport master (
    output r0_valid, r0_cmd, r0_a, r0_b,
    input  r0_ready,
    output r1_valid, r1_cmd, r1_a, r1_b,
    input  r1_ready,
    input  alu_cmd, alu_inA, alu_inB,
    output alu_rslt, alu_branch,
    input  rsp_valid, rsp_id, rsp_rslt, rsp_branch,
    output rsp_ready,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 8-bit ALU between two
// requesters. Round-robin grant in IDLE, operands registered into the ALU,
// result/doBranch captured one cycle later and held on the response channel
// until the consumer accepts it.
// Optional feature macro: ALU_ARB_PERF_EN builds saturating per-requester
// grant counters on cnt0/cnt1; without it both read as 0.
//
// state | meaning
// IDLE  | ALU free, ready offered to the round-robin winner
// EXEC  | ALU evaluating the registered operands, result captured on exit
// RESP  | response presented, waiting for rsp_ready
module alu_arbiter #(
  parameter int CMD_W  = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [CMD_W-1:0]  alu_cmd_q, alu_cmd_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rslt_q, rsp_rslt_d;
  logic              rsp_branch_q, rsp_branch_d;

  logic gnt0, gnt1;

  // Round-robin grant: a lone requester always wins; on a tie the one that
  // was not granted last wins. Only IDLE offers ready.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.r0_valid && bus.r1_valid) begin
        if (last_grant_q) gnt0 = 1'b1;
        else              gnt1 = 1'b1;
      end else begin
        gnt0 = bus.r0_valid;
        gnt1 = bus.r1_valid;
      end
    end
  end

  // Ready is masked while reset is held so every output reads 0 in reset;
  // the state registers themselves never see this gating.
  assign bus.r0_ready = gnt0 & reset_n;
  assign bus.r1_ready = gnt1 & reset_n;

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt0 || gnt1) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: load operands on accept, capture the ALU in EXEC,
  // release the response and park the ALU on NOP after the handshake.
  always_comb begin
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_cmd_d    = alu_cmd_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_rslt_d   = rsp_rslt_q;
    rsp_branch_d = rsp_branch_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          alu_cmd_d    = bus.r0_cmd;
          alu_a_d      = bus.r0_a;
          alu_b_d      = bus.r0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
        end else if (gnt1) begin
          alu_cmd_d    = bus.r1_cmd;
          alu_a_d      = bus.r1_a;
          alu_b_d      = bus.r1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
        end
      end
      S_EXEC: begin
        rsp_rslt_d   = bus.alu_rslt;
        rsp_branch_d = bus.alu_branch;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          alu_cmd_d   = '0;
          alu_a_d     = '0;
          alu_b_d     = '0;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_cmd_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_rslt_q   <= '0;
      rsp_branch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_cmd_q    <= alu_cmd_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_rslt_q   <= rsp_rslt_d;
      rsp_branch_q <= rsp_branch_d;
    end
  end

  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.alu_inA    = alu_a_q;
  assign bus.alu_inB    = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_rslt   = rsp_rslt_q;
  assign bus.rsp_branch = rsp_branch_q;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Grant counters stick at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
    if (gnt1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
  assign bus.cnt0 = '0;
  assign bus.cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter with a small behavioural
// ALU on the far side of the operand registers.
module tb_alu_arbiter;
  localparam int CMD_W  = 5;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_BEQ = 5'b00011;
  localparam logic [4:0] OP_UND = 5'b11111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  alu_arbiter #(.CMD_W(CMD_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External ALU stand-in: only the ops the vectors use, default 0/0.
  always_comb begin
    bus.alu_rslt   = '0;
    bus.alu_branch = 1'b0;
    case (bus.alu_cmd)
      5'b01000: bus.alu_rslt = bus.alu_inA + bus.alu_inB;
      5'b01001: bus.alu_rslt = bus.alu_inA - bus.alu_inB;
      5'b00011: bus.alu_branch = (bus.alu_inA == bus.alu_inB);
      5'b00010, 5'b00001: bus.alu_branch = 1'b1;
      default: ;
    endcase
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One complete op with rsp_ready high; returns the response fields and
  // leaves the DUT back in IDLE at a falling edge.
  task automatic do_op(input logic rid, input logic [4:0] cmd,
                       input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rs, output logic br, output logic id);
    int n;
    bus.rsp_ready = 1'b1;
    if (rid) begin
      bus.r1_cmd = cmd; bus.r1_a = a; bus.r1_b = b; bus.r1_valid = 1'b1;
    end else begin
      bus.r0_cmd = cmd; bus.r0_a = a; bus.r0_b = b; bus.r0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(rid ? bus.r1_ready : bus.r0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk_val("op_grant_timeout", n < 20, 1);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk_val("op_rsp_timeout", n < 20, 1);
    rs = bus.rsp_rslt;
    br = bus.rsp_branch;
    id = bus.rsp_id;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rs;
    logic       br;
    logic       id;
    int         got;
    int         cyc;
    int         seen;

    bus.r0_valid = 1'b1; bus.r0_cmd = OP_ADD; bus.r0_a = 8'h01; bus.r0_b = 8'h02;
    bus.r1_valid = 1'b0; bus.r1_cmd = '0;     bus.r1_a = '0;    bus.r1_b = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with a requester already valid.
    #1;
    chk_val("rst_r0_ready", bus.r0_ready, 0);
    chk_val("rst_rsp_valid", bus.rsp_valid, 0);
    chk_val("rst_alu_cmd", bus.alu_cmd, 0);
    chk_val("rst_cnt0", bus.cnt0, 0);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    reset_n = 1'b1;

    // 1: single r0 ADD 12+34.
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.r0_cmd = OP_ADD; bus.r0_a = 8'h12; bus.r0_b = 8'h34; bus.r0_valid = 1'b1;
    #1;
    chk_val("t1_r0_ready", bus.r0_ready, 1);
    chk_val("t1_r1_ready", bus.r1_ready, 0);
    @(negedge clk);
    chk_val("t1_exec_ready", bus.r0_ready, 0);
    bus.r0_valid = 1'b0;
    chk_val("t1_alu_cmd", bus.alu_cmd, 5'b01000);
    chk_val("t1_alu_inA", bus.alu_inA, 8'h12);
    chk_val("t1_alu_inB", bus.alu_inB, 8'h34);
    chk_val("t1_exec_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk_val("t1_rsp_valid", bus.rsp_valid, 1);
    chk_val("t1_rsp_rslt", bus.rsp_rslt, 8'h46);
    chk_val("t1_rsp_id", bus.rsp_id, 0);
    chk_val("t1_rsp_branch", bus.rsp_branch, 0);
    @(negedge clk);
    chk_val("t1_rsp_cleared", bus.rsp_valid, 0);
    chk_val("t1_alu_nop", bus.alu_cmd, 0);

    // 2: tie from reset, both held; r0 ADD 1+2=3, r1 SUB 9-4=5.
    @(negedge clk);
    reset_n = 1'b0;
    bus.r0_cmd = OP_ADD; bus.r0_a = 8'h01; bus.r0_b = 8'h02; bus.r0_valid = 1'b1;
    bus.r1_cmd = OP_SUB; bus.r1_a = 8'h09; bus.r1_b = 8'h04; bus.r1_valid = 1'b1;
    #1;
    chk_val("t2_rst_r1_ready", bus.r1_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      #1;
      if (bus.rsp_valid) begin
        chk_val("t2_rsp_id", bus.rsp_id, got % 2);
        chk_val("t2_rsp_rslt", bus.rsp_rslt, (got % 2 == 1) ? 8'h05 : 8'h03);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    chk_val("t2_rsp_count", got, 4);

    // 3: backpressure on r1 SUB 5-7, r0 waiting meanwhile.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.r1_cmd = OP_SUB; bus.r1_a = 8'h05; bus.r1_b = 8'h07; bus.r1_valid = 1'b1;
    #1;
    chk_val("t3_r1_ready", bus.r1_ready, 1);
    @(negedge clk);
    bus.r1_valid = 1'b0;
    bus.r0_cmd = OP_ADD; bus.r0_a = 8'h11; bus.r0_b = 8'h22; bus.r0_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_val("t3_hold_valid", bus.rsp_valid, 1);
      chk_val("t3_hold_rslt", bus.rsp_rslt, 8'hFE);
      chk_val("t3_hold_id", bus.rsp_id, 1);
      chk_val("t3_hold_r0_ready", bus.r0_ready, 0);
      chk_val("t3_hold_r1_ready", bus.r1_ready, 0);
      @(negedge clk);
    end
    bus.r0_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk_val("t3_released", bus.rsp_valid, 0);

    // 4: branch results, plus an undefined opcode.
    do_op(1'b0, OP_BEQ, 8'h3C, 8'h3C, rs, br, id);
    chk_val("t4_beq_eq_branch", br, 1);
    chk_val("t4_beq_eq_id", id, 0);
    do_op(1'b0, OP_BEQ, 8'h3C, 8'h3D, rs, br, id);
    chk_val("t4_beq_ne_branch", br, 0);
    do_op(1'b1, OP_UND, 8'hAA, 8'h55, rs, br, id);
    chk_val("t4_und_rslt", rs, 0);
    chk_val("t4_und_branch", br, 0);
    chk_val("t4_und_id", id, 1);

    // 5: reset while r0 op is in EXEC.
    bus.rsp_ready = 1'b1;
    bus.r0_cmd = OP_ADD; bus.r0_a = 8'h10; bus.r0_b = 8'h20; bus.r0_valid = 1'b1;
    #1;
    chk_val("t5_r0_ready", bus.r0_ready, 1);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    chk_val("t5_exec_alu_cmd", bus.alu_cmd, 5'b01000);
    reset_n = 1'b0;
    #1;
    chk_val("t5_rst_alu_cmd", bus.alu_cmd, 0);
    chk_val("t5_rst_alu_inA", bus.alu_inA, 0);
    chk_val("t5_rst_alu_inB", bus.alu_inB, 0);
    chk_val("t5_rst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.r0_ready || bus.r1_ready) seen++;
    end
    chk_val("t5_no_rsp_after_rst", seen, 0);
    bus.r1_cmd = OP_SUB; bus.r1_a = 8'h08; bus.r1_b = 8'h01; bus.r1_valid = 1'b1;
    bus.r0_valid = 1'b1;
    #1;
    chk_val("t5_tie_r0_ready", bus.r0_ready, 1);
    chk_val("t5_tie_r1_ready", bus.r1_ready, 0);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    @(negedge clk);
    chk_val("t5_tie_rsp_valid", bus.rsp_valid, 1);
    chk_val("t5_tie_rsp_id", bus.rsp_id, 0);
    chk_val("t5_tie_rsp_rslt", bus.rsp_rslt, 8'h30);
    @(negedge clk);

    // 6: five r1 ops against 2-bit counters.
    do_reset();
    do_op(1'b1, OP_ADD, 8'h01, 8'h01, rs, br, id);
`ifdef ALU_ARB_PERF_EN
    chk_val("t6_cnt1_first", bus.cnt1, 1);
`else
    chk_val("t6_cnt1_first", bus.cnt1, 0);
`endif
    chk_val("t6_first_rslt", rs, 8'h02);
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, OP_ADD, 8'h01, 8'h01, rs, br, id);
    end
`ifdef ALU_ARB_PERF_EN
    chk_val("t6_cnt1_sat", bus.cnt1, 3);
`else
    chk_val("t6_cnt1_sat", bus.cnt1, 0);
`endif
    chk_val("t6_cnt0", bus.cnt0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
